// File: rtl/i2c_bus_cond_det.sv
// I2C bus condition detector: deglitch filter, SCL edges, START/STOP, bus busy.
// Optional SCL-low bus timeout enabled by defining I2C_BUS_TIMEOUT_EN.
module i2c_bus_cond_det #(
  parameter int FILT_CYC    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic bus_busy_o,
  output logic timeout_o
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);

  // bit 1 = SCL, bit 0 = SDA
  logic [1:0]    raw;
  logic [1:0]    filt;
  logic [1:0]    filt_d;
  logic [CW-1:0] cnt [2];
  logic          scl_d;
  logic          sda_d;

  assign raw   = {scl_i, sda_i};
  assign scl_o = filt[1];
  assign sda_o = filt[0];
  assign scl_d = filt_d[1];
  assign sda_d = filt_d[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 2'b11;
      filt_d <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          filt[i] <= raw[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign scl_rise_o = scl_o & ~scl_d;
  assign scl_fall_o = ~scl_o & scl_d;

  // An SCL change in the same cycle breaks scl_o & scl_d, masking START/STOP.
  assign start_o = ~sda_o & sda_d & scl_o & scl_d;
  assign stop_o  = sda_o & ~sda_d & scl_o & scl_d;

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  logic [TW-1:0] to_cnt;

  assign timeout_o = (to_cnt == TO_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (timeout_o || !bus_busy_o || scl_o) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_busy_o <= 1'b0;
    end else if (start_o) begin
      bus_busy_o <= 1'b1;
    end else if (stop_o || timeout_o) begin
      bus_busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_bus_cond_det.sv
// Randomized + directed bench for i2c_bus_cond_det against a
// sample-window reference model of the filter and bus conditions.
module tb_i2c_bus_cond_det;

  localparam int F = 4;
  localparam int T = 16;
`ifdef I2C_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic scl_i, sda_i;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o;
  logic start_o, stop_o, bus_busy_o, timeout_o;

  int checks = 0;
  int errors = 0;

  i2c_bus_cond_det #(.FILT_CYC(F), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .scl_i(scl_i), .sda_i(sda_i),
    .scl_o(scl_o), .sda_o(sda_o),
    .scl_rise_o(scl_rise_o), .scl_fall_o(scl_fall_o),
    .start_o(start_o), .stop_o(stop_o),
    .bus_busy_o(bus_busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // reference model state
  bit m_fs, m_fd, m_ps, m_pd, m_busy;
  int m_tc;
  bit qs[$];
  bit qd[$];

  // per-test event counters sampled from the DUT
  int n_rise, n_fall, n_st, n_sp, n_to, n_sda_low;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fs = 1; m_fd = 1; m_ps = 1; m_pd = 1;
    m_busy = 0; m_tc = 0;
    qs.delete(); qd.delete();
  endtask

  // new level accepted once the last F samples all differ from it
  function automatic bit win_flip(input bit q[$], input bit f);
    if (q.size() < F) return 1'b0;
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit s, input bit d);
    bit st, sp, to, ob;
    st = !m_fd && m_pd && m_fs && m_ps;
    sp = m_fd && !m_pd && m_fs && m_ps;
    to = TO_EN && (m_tc == T);
    ob = m_busy;
    if (st) m_busy = 1;
    else if (sp || to) m_busy = 0;
    if (to || !ob || m_fs) m_tc = 0;
    else m_tc++;
    qs.push_back(s);
    qd.push_back(d);
    if (qs.size() > F) void'(qs.pop_front());
    if (qd.size() > F) void'(qd.pop_front());
    m_ps = m_fs;
    m_pd = m_fd;
    if (win_flip(qs, m_fs)) m_fs = !m_fs;
    if (win_flip(qd, m_fd)) m_fd = !m_fd;
  endtask

  task automatic compare();
    check("scl_o", scl_o, m_fs);
    check("sda_o", sda_o, m_fd);
    check("rise", scl_rise_o, m_fs & !m_ps);
    check("fall", scl_fall_o, !m_fs & m_ps);
    check("start", start_o, !m_fd & m_pd & m_fs & m_ps);
    check("stop", stop_o, m_fd & !m_pd & m_fs & m_ps);
    check("busy", bus_busy_o, m_busy);
    check("timeout", timeout_o, TO_EN && (m_tc == T));
  endtask

  task automatic clr_counts();
    n_rise = 0; n_fall = 0; n_st = 0;
    n_sp = 0; n_to = 0; n_sda_low = 0;
  endtask

  task automatic step(input bit s, input bit d);
    scl_i = s;
    sda_i = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(s, d);
    #1;
    compare();
    n_rise += int'(scl_rise_o);
    n_fall += int'(scl_fall_o);
    n_st += int'(start_o);
    n_sp += int'(stop_o);
    n_to += int'(timeout_o);
    n_sda_low += int'(!sda_o);
  endtask

  task automatic hold(input bit s, input bit d, input int n);
    for (int i = 0; i < n; i++) step(s, d);
  endtask

  initial begin
    int lat;
    bit b, cs, cd;
    rst = 1'b1;
    scl_i = 1'b1;
    sda_i = 1'b1;
    model_reset();
    #3;
    check("rst_scl", scl_o, 1);
    check("rst_sda", sda_o, 1);
    check("rst_busy", bus_busy_o, 0);
    check("rst_start", start_o, 0);
    hold(1, 1, 2);
    rst = 1'b0;
    hold(1, 1, 4);

    // 1: 3-cycle SDA glitch is suppressed
    clr_counts();
    hold(1, 0, 3);
    hold(1, 1, 8);
    check("t1_sda_low", n_sda_low, 0);
    check("t1_start_stop", n_st + n_sp, 0);

    // 2: START latency and busy
    clr_counts();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1, 0);
      if (!sda_o && lat == 0) begin
        lat = i;
        check("t2_start_at_fall", start_o, 1);
      end
    end
    check("t2_latency", lat, 4);
    check("t2_start_cnt", n_st, 1);
    check("t2_busy", bus_busy_o, 1);

    // 3: nine SCL clocks, SDA moves only mid-low
    clr_counts();
    cd = 0;
    for (int k = 0; k < 9; k++) begin
      b = (k == 8) ? 1'b0 : 1'(($urandom >> 3) & 1);
      hold(0, cd, 2);
      cd = b;
      hold(0, cd, 6);
      hold(1, cd, 8);
    end
    hold(1, cd, 6);
    check("t3_rise", n_rise, 9);
    check("t3_fall", n_fall, 9);
    check("t3_start_stop", n_st + n_sp, 0);
    check("t3_busy", bus_busy_o, 1);

    // 4: STOP, then simultaneous changes
    clr_counts();
    hold(1, 1, 8);
    check("t4_stop", n_sp, 1);
    check("t4_busy", bus_busy_o, 0);
    clr_counts();
    hold(0, 0, 8);
    hold(1, 1, 8);
    check("t4_simul", n_st + n_sp, 0);
    check("t4_simul_rise", n_rise, 1);

    // 5: SCL held low after START
    clr_counts();
    hold(1, 0, 8);
    hold(0, 0, 40);
    check("t5_timeout", n_to, TO_EN ? 1 : 0);
    check("t5_busy", bus_busy_o, TO_EN ? 0 : 1);
    hold(1, 0, 8);
    hold(1, 1, 8);
    check("t5_idle", bus_busy_o, 0);

    // 6: async reset mid-byte
    hold(1, 0, 8);
    hold(0, 0, 8);
    check("t6_pre_busy", bus_busy_o, 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async_sda", sda_o, 1);
    check("t6_async_scl", scl_o, 1);
    check("t6_async_busy", bus_busy_o, 0);
    compare();
    hold(1, 1, 3);
    rst = 1'b0;
    clr_counts();
    hold(1, 1, 10);
    check("t6_no_pulses", n_st + n_sp + n_rise + n_fall, 0);

    // random glitchy bus traffic
    cs = 1;
    cd = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) cs = !cs;
      if ($urandom_range(0, 5) == 0) cd = !cd;
      step(cs, cd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
